// File: rtl/pipelined_adder_if.sv
// Handshake and data bundle for pipelined_adder.
//   in_valid/in_ready     : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready   : result beat handshake (s, cout, ovf)
// modport slave  : the adder side
// modport master : the side that issues operands and consumes results
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor.
// The carry chain is cut into CHUNK-bit slices, one register stage per slice, behind an
// operand register. A beat accepted at edge t is presented at the output after edge
// t+STAGES. The whole pipeline stalls while a result is offered but not taken.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pipelined_adder_if.slave (in_valid/in_ready/a/b/cin/sub,
//          out_valid/out_ready/s/cout/ovf)
// WIDTH must be a positive multiple of CHUNK.
module pipelined_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;

  // Index 0 is the operand register; index k (1..STAGES) is the register after slice k-1.
  logic [STAGES:0]  vld_q, vld_d;
  logic [STAGES:0]  cy_q, cy_d;
  // Skew registers: post-inversion operands travelling towards their own slice.
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opa_d [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];
  // Deskew registers: resolved low slices travelling with the carry. sum_q[0] stays zero.
  logic [WIDTH-1:0] sum_q [STAGES+1];
  logic [WIDTH-1:0] sum_d [STAGES+1];
  logic [CHUNK:0]   slice_sum [STAGES];
  logic             ovf_q, ovf_d;
  logic             stall;

  assign stall = vld_q[STAGES] && !bus.out_ready;

  always_comb begin
    // Operand register: subtraction is a + ~b + 1, so cin is ignored in sub mode.
    opa_d[0] = bus.a;
    opb_d[0] = bus.sub ? ~bus.b : bus.b;
    cy_d[0]  = bus.sub | bus.cin;
    vld_d[0] = bus.in_valid;
    sum_d[0] = '0;

    for (int k = 1; k < STAGES; k++) begin
      opa_d[k] = opa_q[k-1];
      opb_d[k] = opb_q[k-1];
    end

    for (int k = 1; k <= STAGES; k++) begin
      slice_sum[k-1] = {1'b0, opa_q[k-1][(k-1)*CHUNK +: CHUNK]}
                     + {1'b0, opb_q[k-1][(k-1)*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, cy_q[k-1]};
      sum_d[k] = sum_q[k-1];
      sum_d[k][(k-1)*CHUNK +: CHUNK] = slice_sum[k-1][CHUNK-1:0];
      cy_d[k]  = slice_sum[k-1][CHUNK];
      vld_d[k] = vld_q[k-1];
    end

    // Same-sign operands producing a different-sign result.
    ovf_d = (opa_q[STAGES-1][WIDTH-1] == opb_q[STAGES-1][WIDTH-1]) &&
            (sum_d[STAGES][WIDTH-1] != opa_q[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        sum_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
      for (int k = 0; k <= STAGES; k++) begin
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = vld_q[STAGES];
  assign bus.s         = sum_q[STAGES];
  assign bus.cout      = cy_q[STAGES];
  assign bus.ovf       = ovf_q;

endmodule
